// File: rtl/intr_pkg.sv
// intr_pkg: shared definitions for the priority interrupt controller.
//   - FSM state encoding (IDLE / REQ / SERVICE)
//   - default source count, vector base and vector spacing
//   - width of the granted source index
//   - isr_vector(): ISR entry address of a source
package intr_pkg;

  localparam int          N_SRC_DEF     = 4;
  localparam logic [31:0] VEC_BASE_DEF  = 32'h0000_0100;
  localparam int          VEC_SHIFT_DEF = 4;
  localparam int          SRC_ID_W      = 3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_REQ     = 2'b01,
    ST_SERVICE = 2'b10
  } intr_state_e;

  // ISR entry address: base plus the source index scaled by the vector spacing.
  function automatic logic [31:0] isr_vector(input logic [31:0]         base,
                                             input int                  shift,
                                             input logic [SRC_ID_W-1:0] id);
    return base + ({{(32-SRC_ID_W){1'b0}}, id} << shift);
  endfunction

endpackage

// File: rtl/intr_if.sv
// intr_if: interrupt handshake between the controller and the CPU control unit.
//   intr     : interrupt request to the CPU
//   vector   : ISR entry address of the granted source
//   src_id   : granted source index
//   intr_ack : CPU has finished ISR entry setup
//   eoi      : one-cycle pulse when the ISR exit sequence finishes
// modport master = controller side, modport slave = CPU side.
interface intr_if;
  import intr_pkg::*;

  logic                intr;
  logic [31:0]         vector;
  logic [SRC_ID_W-1:0] src_id;
  logic                intr_ack;
  logic                eoi;

  modport master (output intr, vector, src_id, input intr_ack, eoi);
  modport slave  (input intr, vector, src_id, output intr_ack, eoi);
endinterface

// File: rtl/intr_prio_enc.sv
// intr_prio_enc: combinational fixed-priority encoder.
//   req : eligible request vector (N bits)
//   any : at least one request is present
//   id  : index of the lowest set request bit (0 when none)
module intr_prio_enc
  import intr_pkg::*;
#(
  parameter int N = N_SRC_DEF
) (
  input  logic [N-1:0]        req,
  output logic                any,
  output logic [SRC_ID_W-1:0] id
);

  // Scan from the top down so the lowest set index is the last one written.
  always_comb begin
    any = |req;
    id  = {SRC_ID_W{1'b0}};
    for (int i = N - 1; i >= 0; i--) begin
      id = req[i] ? SRC_ID_W'(i) : id;
    end
  end

endmodule

// File: rtl/intr_controller.sv
// intr_controller: multi-source priority interrupt controller.
//   clk, rst    : clock, asynchronous active-high reset
//   irq         : device requests, rising edge raises a request
//   mask_we     : mask register write strobe
//   mask_wdata  : new mask value (1 = source disabled)
//   cpu         : CPU handshake (intr, vector, src_id out; intr_ack, eoi in)
//   pending     : latched requests, readable by software
//   mask        : current mask
//   busy        : a request is outstanding or being serviced
module intr_controller
  import intr_pkg::*;
#(
  parameter int          N_SRC     = N_SRC_DEF,
  parameter logic [31:0] VEC_BASE  = VEC_BASE_DEF,
  parameter int          VEC_SHIFT = VEC_SHIFT_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_SRC-1:0] irq,
  input  logic             mask_we,
  input  logic [N_SRC-1:0] mask_wdata,
  intr_if.master           cpu,
  output logic [N_SRC-1:0] pending,
  output logic [N_SRC-1:0] mask,
  output logic             busy
);

  intr_state_e         state_r;
  intr_state_e         state_n_s;
  logic [N_SRC-1:0]    irq_q_r;
  logic [N_SRC-1:0]    pending_r;
  logic [N_SRC-1:0]    mask_r;
  logic                intr_r;
  logic                busy_r;
  logic [SRC_ID_W-1:0] src_id_r;
  logic [31:0]         vector_r;

  logic [N_SRC-1:0]    edge_s;
  logic [N_SRC-1:0]    elig_s;
  logic [N_SRC-1:0]    clr_s;
  logic                any_s;
  logic [SRC_ID_W-1:0] enc_id_s;
  logic                grant_s;

  assign edge_s = irq & ~irq_q_r;
  // Arbitration always sees the mask as it was before any write this cycle.
  assign elig_s = pending_r & ~mask_r;

  intr_prio_enc #(.N(N_SRC)) u_prio_enc (
    .req (elig_s),
    .any (any_s),
    .id  (enc_id_s)
  );

  // Next-state decode; a grant happens only when leaving IDLE.
  always_comb begin
    state_n_s = state_r;
    grant_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (any_s) begin
          grant_s   = 1'b1;
          state_n_s = ST_REQ;
        end else begin
          state_n_s = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (cpu.intr_ack) begin
          state_n_s = ST_SERVICE;
        end else begin
          state_n_s = ST_REQ;
        end
      end
      ST_SERVICE: begin
        if (cpu.eoi) begin
          state_n_s = ST_IDLE;
        end else begin
          state_n_s = ST_SERVICE;
        end
      end
      default: begin
        state_n_s = ST_IDLE;
      end
    endcase
  end

  // One-hot clear of the granted source's pending bit.
  always_comb begin
    if (grant_s) begin
      clr_s = N_SRC'(1'b1) << enc_id_s;
    end else begin
      clr_s = {N_SRC{1'b0}};
    end
  end

  // FSM state plus the intr/busy outputs registered from the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
      intr_r  <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_n_s;
      intr_r  <= (state_n_s == ST_REQ);
      busy_r  <= (state_n_s != ST_IDLE);
    end
  end

  // Edge history, pending latch (a new edge beats a same-cycle clear) and mask.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      irq_q_r   <= {N_SRC{1'b0}};
      pending_r <= {N_SRC{1'b0}};
      mask_r    <= {N_SRC{1'b1}};
    end else begin
      irq_q_r   <= irq;
      pending_r <= (pending_r & ~clr_s) | edge_s;
      if (mask_we) begin
        mask_r <= mask_wdata;
      end else begin
        mask_r <= mask_r;
      end
    end
  end

  // Granted source and its vector hold until the next grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      src_id_r <= {SRC_ID_W{1'b0}};
      vector_r <= VEC_BASE;
    end else if (grant_s) begin
      src_id_r <= enc_id_s;
      vector_r <= isr_vector(VEC_BASE, VEC_SHIFT, enc_id_s);
    end else begin
      src_id_r <= src_id_r;
      vector_r <= vector_r;
    end
  end

  assign cpu.intr   = intr_r;
  assign cpu.vector = vector_r;
  assign cpu.src_id = src_id_r;
  assign pending    = pending_r;
  assign mask       = mask_r;
  assign busy       = busy_r;

endmodule

// File: tb/tb_intr_controller.sv
// tb_intr_controller: self-checking bench for intr_controller.
// A behavioural model tracks pending/mask/phase from the rules of the block
// and is compared against the DUT on every falling edge; directed scenarios
// add literal expectations, followed by a randomized run.
module tb_intr_controller;
  import intr_pkg::*;

  localparam int N = 4;
  localparam int PH_IDLE = 0;
  localparam int PH_REQ  = 1;
  localparam int PH_SVC  = 2;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] irq = '0;
  logic         mask_we = 1'b0;
  logic [N-1:0] mask_wdata = '0;
  logic [N-1:0] pending;
  logic [N-1:0] mask;
  logic         busy;

  intr_if bus ();

  intr_controller #(.N_SRC(N), .VEC_BASE(32'h0000_0100), .VEC_SHIFT(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .irq        (irq),
    .mask_we    (mask_we),
    .mask_wdata (mask_wdata),
    .cpu        (bus),
    .pending    (pending),
    .mask       (mask),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [N-1:0] m_pend = '0;
  logic [N-1:0] m_mask = '1;
  logic [N-1:0] m_prev = '0;
  int           m_phase = PH_IDLE;
  int           m_id = 0;
  logic [31:0]  m_vec = 32'h100;
  int           win;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_pend  = '0;
      m_mask  = '1;
      m_prev  = '0;
      m_phase = PH_IDLE;
      m_id    = 0;
      m_vec   = 32'h100;
    end else begin
      win = -1;
      if (m_phase == PH_IDLE) begin
        for (int i = 0; i < N; i++)
          if (win < 0 && m_pend[i] && !m_mask[i]) win = i;
        if (win >= 0) begin
          m_id   = win;
          m_vec  = 32'h100 + 32'(win * 16);
          m_pend[win] = 1'b0;
          m_phase = PH_REQ;
        end
      end else if (m_phase == PH_REQ) begin
        if (bus.intr_ack) m_phase = PH_SVC;
      end else begin
        if (bus.eoi) m_phase = PH_IDLE;
      end
      m_pend = m_pend | (irq & ~m_prev);
      if (mask_we) m_mask = mask_wdata;
      m_prev = irq;
    end
  end

  // ---------------- per-cycle compare ----------------
  int   dut_grants = 0;
  logic intr_prev = 1'b0;

  always @(negedge clk) begin
    if (!rst) begin
      chk("intr",    32'(bus.intr),   32'(m_phase == PH_REQ));
      chk("busy",    32'(busy),       32'(m_phase != PH_IDLE));
      chk("pending", 32'(pending),    32'(m_pend));
      chk("mask",    32'(mask),       32'(m_mask));
      chk("src_id",  32'(bus.src_id), 32'(m_id));
      chk("vector",  bus.vector,      m_vec);
    end
    if (bus.intr && !intr_prev) dut_grants++;
    intr_prev = bus.intr;
  end

  task automatic tick();
    @(negedge clk);
  endtask

  // Acknowledge, then end the ISR; leaves the DUT in IDLE.
  task automatic service();
    bus.intr_ack = 1'b1; tick(); bus.intr_ack = 1'b0;
    bus.eoi = 1'b1;      tick(); bus.eoi = 1'b0;
  endtask

  int g0;

  initial begin
    bus.intr_ack = 1'b0;
    bus.eoi      = 1'b0;
    repeat (2) tick();
    // reset values
    chk("rst_intr",    32'(bus.intr),   32'd0);
    chk("rst_busy",    32'(busy),       32'd0);
    chk("rst_pending", 32'(pending),    32'd0);
    chk("rst_mask",    32'(mask),       32'hF);
    chk("rst_src_id",  32'(bus.src_id), 32'd0);
    chk("rst_vector",  bus.vector,      32'h100);
    rst = 1'b0;
    tick();

    // single source 2
    mask_we = 1'b1; mask_wdata = 4'b0000; tick(); mask_we = 1'b0;
    irq = 4'b0100; tick();
    chk("t1_pend", 32'(pending), 32'h4);
    chk("t1_nointr", 32'(bus.intr), 32'd0);
    irq = 4'b0000; tick();
    chk("t1_intr", 32'(bus.intr), 32'd1);
    chk("t1_id", 32'(bus.src_id), 32'd2);
    chk("t1_vec", bus.vector, 32'h120);
    bus.intr_ack = 1'b1; tick(); bus.intr_ack = 1'b0;
    chk("t1_ackdrop", 32'(bus.intr), 32'd0);
    bus.eoi = 1'b1; tick(); bus.eoi = 1'b0;

    // simultaneous 3 and 1
    irq = 4'b1010; tick(); irq = 4'b0000; tick();
    chk("t2_vec1", bus.vector, 32'h110);
    chk("t2_pend", 32'(pending), 32'h8);
    bus.intr_ack = 1'b1; tick(); bus.intr_ack = 1'b0;
    bus.eoi = 1'b1; tick(); bus.eoi = 1'b0;
    chk("t2_idle", 32'(bus.intr), 32'd0);
    tick();
    chk("t2_vec3", bus.vector, 32'h130);
    chk("t2_id3", 32'(bus.src_id), 32'd3);
    service();

    // masked source then unmask
    mask_we = 1'b1; mask_wdata = 4'b0100; tick(); mask_we = 1'b0;
    irq = 4'b0100; tick(); irq = 4'b0000; tick(); tick();
    chk("t3_pend", 32'(pending), 32'h4);
    chk("t3_nointr", 32'(bus.intr), 32'd0);
    mask_we = 1'b1; mask_wdata = 4'b0000; tick(); mask_we = 1'b0;
    chk("t3_oldmask", 32'(bus.intr), 32'd0);
    tick();
    chk("t3_intr", 32'(bus.intr), 32'd1);
    service();

    // edge during SERVICE waits for eoi
    irq = 4'b0010; tick(); irq = 4'b0000; tick();
    bus.intr_ack = 1'b1; tick(); bus.intr_ack = 1'b0;
    irq = 4'b0001; tick(); irq = 4'b0000; tick(); tick();
    chk("t4_pend0", 32'(pending), 32'h1);
    chk("t4_nointr", 32'(bus.intr), 32'd0);
    bus.eoi = 1'b1; tick(); bus.eoi = 1'b0;
    chk("t4_gap", 32'(bus.intr), 32'd0);
    tick();
    chk("t4_vec0", bus.vector, 32'h100);
    chk("t4_intr", 32'(bus.intr), 32'd1);
    service();

    // level-held request gives one grant
    g0 = dut_grants;
    irq = 4'b0010;
    for (int c = 0; c < 20; c++) begin
      tick();
      bus.intr_ack = bus.intr;
      bus.eoi      = busy && !bus.intr && !bus.intr_ack;
    end
    irq = 4'b0000; bus.intr_ack = 1'b0; bus.eoi = 1'b0;
    repeat (4) tick();
    chk("t5_one_grant", 32'(dut_grants - g0), 32'd1);
    chk("t5_idle", 32'(busy), 32'd0);

    // eoi ignored in IDLE and REQ; reset in REQ
    bus.eoi = 1'b1; tick(); bus.eoi = 1'b0;
    chk("t6_idle_eoi", 32'(busy), 32'd0);
    irq = 4'b1000; tick(); irq = 4'b0000; tick();
    bus.eoi = 1'b1; tick(); bus.eoi = 1'b0;
    chk("t6_req_eoi", 32'(bus.intr), 32'd1);
    irq = 4'b0001; tick(); irq = 4'b0000; tick();
    chk("t6_pend", 32'(pending), 32'h1);
    #2 rst = 1'b1;
    #1;
    chk("t6_rst_intr", 32'(bus.intr), 32'd0);
    chk("t6_rst_pend", 32'(pending), 32'd0);
    chk("t6_rst_mask", 32'(mask), 32'hF);
    tick(); rst = 1'b0; tick();

    // randomized run
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 3) == 0) irq = irq ^ N'($urandom_range(0, 15));
      mask_we    = ($urandom_range(0, 19) == 0);
      mask_wdata = N'($urandom) & N'($urandom);
      bus.intr_ack = bus.intr ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 9) == 0);
      bus.eoi      = ($urandom_range(0, 4) == 0);
      if (c == 2000) rst = 1'b1;
      else rst = 1'b0;
      tick();
    end
    rst = 1'b0; irq = '0; mask_we = 1'b0; bus.intr_ack = 1'b0; bus.eoi = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
